// File: rtl/button_debounce_if.sv
// Pin-side and user-side signals of the push-button conditioner, bundled for port hookup.
// No valid/ready here: btn_in is a free-running level, and every *_pulse is a one-cycle strobe that the consumer must sample every clk.
interface button_debounce_if;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  modport master (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, short_pulse, long_pulse, press_count
  );

  modport slave (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, short_pulse, long_pulse, press_count
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, two-edge debounce, short/long press
// classification and a wrapping press counter. All outputs are registered.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  button_debounce_if.master     bus,
  output logic [2:0]            dbg_state
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW  = $clog2(LONG_CYCLES + 1);
  localparam logic          INACTIVE  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DB  = 3'd1,
    PRESSED   = 3'd2,
    LONG_HELD = 3'd3,
    REL_DB    = 3'd4
  } state_t;

  state_t         state;
  logic           sync1, sync2;
  logic           act;
  logic [DBW-1:0] db_cnt;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_next;
  logic           hold_reached;
  logic           long_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= INACTIVE;
      sync2 <= INACTIVE;
    end else begin
      sync1 <= bus.btn_in;
      sync2 <= sync1;
    end
  end

  assign act = sync2 ^ INACTIVE;

  // The long threshold is judged on the value hold_cnt will take this edge, so
  // long_pulse lands exactly LONG_CYCLES edges after the press_pulse edge.
  assign hold_next    = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
  assign hold_reached = (hold_cnt >= HOLD_LAST);
  assign dbg_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      db_cnt            <= '0;
      hold_cnt          <= '0;
      long_flag         <= 1'b0;
      bus.btn_level     <= 1'b0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.short_pulse   <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.press_count   <= '0;
    end else begin
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.short_pulse   <= 1'b0;
      bus.long_pulse    <= 1'b0;
      if (state == PRESSED || state == LONG_HELD || state == REL_DB)
        hold_cnt <= hold_next;

      case (state)
        IDLE: begin
          db_cnt <= '0;
          if (act) state <= PRESS_DB;
        end

        PRESS_DB: begin
          if (!act) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state           <= PRESSED;
            db_cnt          <= '0;
            hold_cnt        <= '0;
            bus.press_pulse <= 1'b1;
            bus.btn_level   <= 1'b1;
            bus.press_count <= bus.press_count + 8'd1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        PRESSED: begin
          db_cnt <= '0;
          if (hold_reached) begin
            state          <= LONG_HELD;
            long_flag      <= 1'b1;
            bus.long_pulse <= 1'b1;
          end else if (!act) begin
            state <= REL_DB;
          end
        end

        LONG_HELD: begin
          db_cnt <= '0;
          if (!act) state <= REL_DB;
        end

        REL_DB: begin
          if (act) begin
            db_cnt <= '0;
            // A long threshold crossed while bouncing is honoured on the return edge.
            if (long_flag) begin
              state <= LONG_HELD;
            end else if (hold_reached) begin
              state          <= LONG_HELD;
              long_flag      <= 1'b1;
              bus.long_pulse <= 1'b1;
            end else begin
              state <= PRESSED;
            end
          end else if (db_cnt == DB_LAST) begin
            state             <= IDLE;
            db_cnt            <= '0;
            hold_cnt          <= '0;
            long_flag         <= 1'b0;
            bus.btn_level     <= 1'b0;
            bus.release_pulse <= 1'b1;
            bus.short_pulse   <= ~long_flag;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low pin.
module tb_button_debounce;
  localparam int DB = 4;
  localparam int LC = 20;

  // pulse-vector bits: {level, press, release, short, long}
  localparam logic [4:0] P0 = 5'b00000;
  localparam logic [4:0] LV = 5'b10000;
  localparam logic [4:0] PR = 5'b01000;
  localparam logic [4:0] RL = 5'b00100;
  localparam logic [4:0] SH = 5'b00010;
  localparam logic [4:0] LG = 5'b00001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_debounce_if bus();
  logic [2:0] dbg_state;

  button_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LC),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [12:0] exp_q[$];
  logic [7:0] exp_cnt;

  typedef struct {
    logic       btn;
    int         reps;
    logic [4:0] pulses;
    logic [7:0] count;
    string      name;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [12:0] observe();
    return {bus.btn_level, bus.press_pulse, bus.release_pulse,
            bus.short_pulse, bus.long_pulse, bus.press_count};
  endfunction

  task automatic check_pop(input string name);
    logic [12:0] exp;
    logic [12:0] got;
    exp = exp_q.pop_front();
    got = observe();
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got lvl/prs/rel/sht/lng=%b cnt=%0d, want %b cnt=%0d",
               name, $time, got[12:8], got[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input logic b, input logic [4:0] p, input logic [7:0] c,
                           input string name);
    bus.btn_in = b;
    exp_q.push_back({p, c});
    tick();
    check_pop(name);
  endtask

  task automatic add(input logic b, input int reps, input logic [4:0] p,
                     input logic [7:0] c, input string name);
    vec_t v;
    v.btn = b; v.reps = reps; v.pulses = p; v.count = c; v.name = name;
    vecs.push_back(v);
  endtask

  // Clean press of a released pin: pulse appears on the 7th sampling edge.
  task automatic clean_press(input string name);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, P0, exp_cnt, name);
    exp_cnt = exp_cnt + 8'd1;
    run_cycle(1'b0, LV | PR, exp_cnt, name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.btn_in = 1'b1;
    exp_cnt = 8'd0;

    // Vector table: clean press + short click, bouncy press, long press.
    add(1'b0, 6,  P0,           8'd0, "clean_wait");
    add(1'b0, 1,  LV | PR,      8'd1, "clean_press");
    add(1'b0, 10, LV,           8'd1, "short_hold");
    add(1'b1, 6,  LV,           8'd1, "short_rel_wait");
    add(1'b1, 1,  RL | SH,      8'd1, "short_release");
    add(1'b1, 3,  P0,           8'd1, "short_idle");
    add(1'b0, 1,  P0,           8'd1, "bounce0");
    add(1'b1, 1,  P0,           8'd1, "bounce1");
    add(1'b0, 1,  P0,           8'd1, "bounce2");
    add(1'b0, 1,  P0,           8'd1, "bounce3");
    add(1'b1, 1,  P0,           8'd1, "bounce4");
    add(1'b0, 6,  P0,           8'd1, "bounce_wait");
    add(1'b0, 1,  LV | PR,      8'd2, "bounce_press");
    add(1'b0, 3,  LV,           8'd2, "bounce_hold");
    add(1'b1, 6,  LV,           8'd2, "bounce_rel_wait");
    add(1'b1, 1,  RL | SH,      8'd2, "bounce_release");
    add(1'b1, 3,  P0,           8'd2, "bounce_idle");
    add(1'b0, 6,  P0,           8'd2, "long_wait");
    add(1'b0, 1,  LV | PR,      8'd3, "long_press");
    add(1'b0, 19, LV,           8'd3, "long_hold");
    add(1'b0, 1,  LV | LG,      8'd3, "long_pulse");
    add(1'b0, 10, LV,           8'd3, "long_keep");
    add(1'b1, 6,  LV,           8'd3, "long_rel_wait");
    add(1'b1, 1,  RL,           8'd3, "long_release");
    add(1'b1, 3,  P0,           8'd3, "long_idle");

    // Reset state
    repeat (3) tick();
    exp_q.push_back({P0, 8'd0});
    check_pop("reset_state");
    rst_n = 1'b1;
    run_cycle(1'b1, P0, 8'd0, "post_reset_idle");

    foreach (vecs[i])
      for (int r = 0; r < vecs[i].reps; r++)
        run_cycle(vecs[i].btn, vecs[i].pulses, vecs[i].count, vecs[i].name);
    exp_cnt = 8'd3;

    // Release bounce around the long threshold: long fires on the return edge.
    clean_press("relb_press");
    for (int e = 1; e <= 31; e++)
      run_cycle(((e >= 16 && e <= 17) || e >= 25) ? 1'b1 : 1'b0,
                (e < 31 ? LV : P0) | (e == 20 ? LG : P0) | (e == 31 ? RL : P0),
                exp_cnt, "relb_seq");
    for (int i = 0; i < 3; i++) run_cycle(1'b1, P0, exp_cnt, "relb_idle");

    // Threshold crossed while releasing, release accepted: short, never long.
    clean_press("pend_press");
    for (int e = 1; e <= 22; e++)
      run_cycle((e >= 16) ? 1'b1 : 1'b0,
                (e < 22) ? LV : (RL | SH), exp_cnt, "pend_seq");
    for (int i = 0; i < 3; i++) run_cycle(1'b1, P0, exp_cnt, "pend_idle");

    // Counter wrap from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    run_cycle(1'b1, P0, exp_cnt, "wrap_start");
    for (int p = 0; p < 256; p++) begin
      clean_press("wrap_press");
      for (int i = 0; i < 6; i++) run_cycle(1'b1, LV, exp_cnt, "wrap_rel_wait");
      run_cycle(1'b1, RL | SH, exp_cnt, "wrap_release");
      run_cycle(1'b1, P0, exp_cnt, "wrap_idle");
    end
    n_cmp++;
    if (bus.press_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d, want 0", bus.press_count);
    end

    // Reset mid-hold: outputs drop without a clock edge, then re-qualify.
    clean_press("rst_press");
    for (int i = 0; i < 5; i++) run_cycle(1'b0, LV, exp_cnt, "rst_hold");
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back({P0, 8'd0});
    check_pop("rst_async_drop");
    tick();
    exp_q.push_back({P0, 8'd0});
    check_pop("rst_held");
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    clean_press("rst_requalify");
    for (int i = 0; i < 3; i++) run_cycle(1'b0, LV, exp_cnt, "rst_after_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
